// File: rtl/iir_result_checker_pkg.sv
// Shared types and default widths for the IIR result checker, its bench and the filter instance.
package iir_tb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

  localparam int NB_DEF   = 10;
  localparam int CNTW_DEF = 16;
endpackage

// File: rtl/iir_result_checker_if.sv
// Golden-sample stream (valid/ready) plus DUT sample stream (valid only, no backpressure).
interface iir_result_checker_if import iir_tb_pkg::*; #(
  parameter int Nb = NB_DEF
);
  logic [Nb-1:0] EXP_DATA;
  logic          EXP_VALID;
  logic          EXP_READY;
  logic [Nb-1:0] DOUT;
  logic          VOUT;

  modport master (output EXP_DATA, EXP_VALID, DOUT, VOUT, input EXP_READY);
  modport slave  (input EXP_DATA, EXP_VALID, DOUT, VOUT, output EXP_READY);
endinterface

// File: rtl/iir_result_checker_fifo.sv
// Golden-sample FIFO: DEPTH x W, head visible combinationally, flush restarts it empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      // a sample arriving with the flush becomes the new head
      rd_d = '0;
      wr_d = '0;
      if (push) begin
        mem_d[0] = din;
        wr_d     = (AW+1)'(1);
      end
    end else begin
      if (push) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign head  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/iir_result_checker.sv
// Compares DUT samples in order against buffered golden samples; counts samples/errors,
// flags overrun (DUT sample with no golden) and DUT stall (timeout).
module iir_result_checker import iir_tb_pkg::*; #(
  parameter int Nb      = NB_DEF,
  parameter int DEPTH   = 8,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = CNTW_DEF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              START,
  input  logic [CNTW-1:0]   N_EXPECT,
  iir_result_checker_if.slave bus,
  output logic              MISMATCH,
  output logic [CNTW-1:0]   SMP_CNT,
  output logic [CNTW-1:0]   ERR_CNT,
  output logic [CNTW-1:0]   FIRST_ERR,
  output logic              DONE,
  output logic              PASS,
  output logic              TIMED_OUT
);
  localparam int            IDW   = $clog2(TIMEOUT);
  localparam logic [Nb:0]   TOL_V = (Nb+1)'(TOL);

  chk_state_t      state_q, state_d;
  logic [CNTW-1:0] n_exp_q, n_exp_d, smp_q, smp_d, err_q, err_d, first_q, first_d;
  logic [IDW-1:0]  idle_q, idle_d;
  logic            mismatch_q, mismatch_d, to_q, to_d;

  logic [Nb-1:0]   head;
  logic            fifo_full, fifo_empty, push, pop, flush, in_run, fail;
  logic [Nb:0]     diff, abs_diff;

  assign in_run = (state_q == iir_tb_pkg::RUN);
  assign push   = bus.EXP_VALID && bus.EXP_READY;
  assign pop    = in_run && bus.VOUT && !START && !fifo_empty;
  assign flush  = START && (state_q != iir_tb_pkg::IDLE);

  assign bus.EXP_READY = RST_n && (state_q != iir_tb_pkg::DONE) && !fifo_full;

  sync_fifo #(.DEPTH(DEPTH), .W(Nb)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.EXP_DATA),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // one extra bit so full-scale differences (e.g. 511 - -512) cannot wrap
  assign diff     = {bus.DOUT[Nb-1], bus.DOUT} - {head[Nb-1], head};
  assign abs_diff = diff[Nb] ? -diff : diff;
  assign fail     = fifo_empty || (abs_diff > TOL_V);

  always_comb begin
    state_d    = state_q;
    n_exp_d    = n_exp_q;
    smp_d      = smp_q;
    err_d      = err_q;
    first_d    = first_q;
    idle_d     = idle_q;
    to_d       = to_q;
    mismatch_d = 1'b0;
    if (START) begin
      n_exp_d = N_EXPECT;
      smp_d   = '0;
      err_d   = '0;
      first_d = '1;
      idle_d  = '0;
      to_d    = 1'b0;
      state_d = (N_EXPECT == '0) ? iir_tb_pkg::DONE : iir_tb_pkg::RUN;
    end else if (in_run) begin
      if (bus.VOUT) begin
        idle_d = '0;
        smp_d  = smp_q + 1'b1;
        if (fail) begin
          mismatch_d = 1'b1;
          if (err_q != '1)   err_d   = err_q + 1'b1;
          if (first_q == '1) first_d = smp_q;
        end
        if (smp_d == n_exp_q) state_d = iir_tb_pkg::DONE;
      end else if (idle_q == IDW'(TIMEOUT-1)) begin
        state_d = iir_tb_pkg::DONE;
        to_d    = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q    <= iir_tb_pkg::IDLE;
      n_exp_q    <= '0;
      smp_q      <= '0;
      err_q      <= '0;
      first_q    <= '1;
      idle_q     <= '0;
      to_q       <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_exp_q    <= n_exp_d;
      smp_q      <= smp_d;
      err_q      <= err_d;
      first_q    <= first_d;
      idle_q     <= idle_d;
      to_q       <= to_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign MISMATCH  = mismatch_q;
  assign SMP_CNT   = smp_q;
  assign ERR_CNT   = err_q;
  assign FIRST_ERR = first_q;
  assign DONE      = (state_q == iir_tb_pkg::DONE);
  assign PASS      = DONE && !to_q && (err_q == '0);
  assign TIMED_OUT = to_q;
endmodule
